// File: rtl/ps2_note_tracker.sv
// PS/2 scancode decoder with a last-pressed-wins stack of held note keys.
// Stage 1 tracks make/break sequences; stage 2 registers the top key's half-period.
module ps2_note_tracker #(
  parameter int STACK_DEPTH = 4,
  parameter int PERIOD_W    = 20
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rx_valid,
  input  logic [7:0]          rx_byte,
  input  logic                all_off,
  output logic [PERIOD_W-1:0] note_period,
  output logic                note_valid,
  output logic [7:0]          key_code,
  output logic [3:0]          held_count,
  output logic                overflow
);

  typedef enum logic [1:0] {ST_IDLE, ST_BRK, ST_EXT, ST_EXT_BRK} state_t;

  state_t     state_r;
  logic [7:0] stack_r      [STACK_DEPTH];
  logic [3:0] count_r;
  logic       ovf_r;

  logic [7:0] stack_make_s [STACK_DEPTH];
  logic [3:0] count_make_s;
  logic       ovf_make_s;
  logic       hit_s;
  logic [7:0] stack_brk_s  [STACK_DEPTH];
  logic [3:0] count_brk_s;
  logic       found_s;
  logic [7:0] top_code_s;
  logic       mapped_s;

  // Half-period counts at 100 MHz; zero marks a code with no note.
  function automatic logic [19:0] note_lookup(input logic [7:0] code);
    case (code)
      8'h15: note_lookup = 20'h5D2EF;
      8'h1D: note_lookup = 20'h53232;
      8'h24: note_lookup = 20'h4A113;
      8'h2D: note_lookup = 20'h45E90;
      8'h2C: note_lookup = 20'h3E47E;
      8'h35: note_lookup = 20'h377C8;
      8'h3C: note_lookup = 20'h316EE;
      8'h43: note_lookup = 20'h2EA85;
      8'h1C: note_lookup = 20'h2EA85;
      8'h1B: note_lookup = 20'h29919;
      8'h23: note_lookup = 20'h25085;
      8'h2B: note_lookup = 20'h22F44;
      8'h34: note_lookup = 20'h1F23F;
      8'h33: note_lookup = 20'h1BBE4;
      8'h3B: note_lookup = 20'h18B77;
      8'h42: note_lookup = 20'h17544;
      8'h1A: note_lookup = 20'h17544;
      8'h22: note_lookup = 20'h14C8B;
      8'h21: note_lookup = 20'h12843;
      8'h2A: note_lookup = 20'h117A2;
      8'h32: note_lookup = 20'h0F920;
      8'h31: note_lookup = 20'h0DDF2;
      8'h3A: note_lookup = 20'h0C5BB;
      8'h41: note_lookup = 20'h0BA8B;
      default: note_lookup = 20'h00000;
    endcase
  endfunction

  assign mapped_s = (note_lookup(rx_byte) != 20'h00000);

  // Stack image after a make of rx_byte: repeat is a no-op, full stack evicts the oldest.
  always_comb begin
    hit_s        = 1'b0;
    count_make_s = count_r;
    ovf_make_s   = 1'b0;
    stack_make_s = stack_r;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      hit_s = hit_s | ((i < int'(count_r)) && (stack_r[i] == rx_byte));
    end
    if (hit_s) begin
      count_make_s = count_r;
    end else if (int'(count_r) >= STACK_DEPTH) begin
      for (int i = 0; i < STACK_DEPTH - 1; i++) begin
        stack_make_s[i] = stack_r[i+1];
      end
      stack_make_s[STACK_DEPTH-1] = rx_byte;
      ovf_make_s = 1'b1;
    end else begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (i == int'(count_r)) begin
          stack_make_s[i] = rx_byte;
        end else begin
          stack_make_s[i] = stack_r[i];
        end
      end
      count_make_s = count_r + 4'd1;
    end
  end

  // Stack image after a break of rx_byte: entries above the match slide down one slot.
  always_comb begin
    found_s     = 1'b0;
    stack_brk_s = stack_r;
    for (int i = 0; i < STACK_DEPTH - 1; i++) begin
      found_s        = found_s | ((i < int'(count_r)) && (stack_r[i] == rx_byte));
      stack_brk_s[i] = found_s ? stack_r[i+1] : stack_r[i];
    end
    found_s = found_s | ((STACK_DEPTH - 1 < int'(count_r)) && (stack_r[STACK_DEPTH-1] == rx_byte));
    stack_brk_s[STACK_DEPTH-1] = found_s ? 8'h00 : stack_r[STACK_DEPTH-1];
    if (found_s) begin
      count_brk_s = count_r - 4'd1;
    end else begin
      count_brk_s = count_r;
    end
  end

  // Newest held key, or 0x00 when the stack is empty.
  always_comb begin
    top_code_s = 8'h00;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (i == int'(count_r) - 1) begin
        top_code_s = stack_r[i];
      end else begin
        top_code_s = top_code_s;
      end
    end
  end

  // Stage 1: decoder FSM and stack update; all_off wins over a coincident byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      stack_r <= '{default: 8'h00};
      count_r <= 4'd0;
      ovf_r   <= 1'b0;
    end else if (all_off) begin
      state_r <= ST_IDLE;
      stack_r <= '{default: 8'h00};
      count_r <= 4'd0;
      ovf_r   <= 1'b0;
    end else if (rx_valid) begin
      ovf_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_byte == 8'hF0) begin
            state_r <= ST_BRK;
          end else if (rx_byte == 8'hE0) begin
            state_r <= ST_EXT;
          end else if (mapped_s) begin
            stack_r <= stack_make_s;
            count_r <= count_make_s;
            ovf_r   <= ovf_make_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BRK: begin
          if (rx_byte == 8'hF0) begin
            state_r <= ST_BRK;
          end else begin
            stack_r <= stack_brk_s;
            count_r <= count_brk_s;
            state_r <= ST_IDLE;
          end
        end
        ST_EXT: begin
          if (rx_byte == 8'hF0) begin
            state_r <= ST_EXT_BRK;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_EXT_BRK: state_r <= ST_IDLE;
        default:    state_r <= ST_IDLE;
      endcase
    end else begin
      ovf_r <= 1'b0;
    end
  end

  // Stage 2: registered note lookup and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      note_period <= '0;
      note_valid  <= 1'b0;
      key_code    <= 8'h00;
      held_count  <= 4'd0;
      overflow    <= 1'b0;
    end else begin
      note_period <= PERIOD_W'(note_lookup(top_code_s));
      note_valid  <= (count_r != 4'd0);
      key_code    <= top_code_s;
      held_count  <= count_r;
      overflow    <= ovf_r;
    end
  end

endmodule
